dma_channel_arbiter: RTL
========================

// Module: dma_channel_arbiter
// PURPOSE
//  Shares the single byte-copy DMA engine among NUM_CH requesting channels.
//  - Round-robin selection among pending requests.
//  - Latches the winner's descriptor (src/dest/len), issues a 1-cycle start, waits for the engine's done.
//  - Returns a per-channel completion pulse.
//  - Sits between channel clients and the engine's CPU-side interface.
// PARAMETERS
//  NUM_CH     4    number of requesting channels (2..8)
//  AW         8    address width of src/dest
//  LW         8    length width
//  WD_CYCLES  1023 watchdog limit: max BUSY cycles before fault (10-bit counter)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst_n      in   1          asynchronous reset, active low
//  req        in   NUM_CH     level request per channel; held until ch_done/ch_err
//  ch_src     in   NUM_CH*AW  packed source addresses, channel i at [i*AW +: AW]
//  ch_dest    in   NUM_CH*AW  packed destination addresses
//  ch_len     in   NUM_CH*LW  packed byte counts
//  grant      out  NUM_CH     one-hot, high while channel owns the engine
//  ch_done    out  NUM_CH     1-cycle pulse: channel's transfer complete
//  ch_err     out  NUM_CH     1-cycle pulse: zero-length reject or watchdog expiry
//  fault      out  1          sticky watchdog fault; cleared only by rst_n
//  dma_start  out  1          1-cycle start pulse to engine
//  dma_src    out  AW         latched source address to engine
//  dma_dest   out  AW         latched destination address
//  dma_length out  LW         latched length
//  dma_done   in   1          engine done flag (level, cleared by engine on start)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = NUM_CH-1 (ch0 wins first); dma_done_q=0.
//  Completion detect: done_rise = dma_done & ~dma_done_q; raw level is never used.
//  FSM:
//   IDLE
//    - req==0 -> stay.
//    - Else winner = first set req index searching ptr+1, ptr+2, ... modulo NUM_CH; ptr<=winner.
//    - len==0: ch_err[winner] pulse next cycle, no start, stay IDLE.
//    - len!=0: latch descriptor into dma_* regs, grant<=onehot(winner), dma_start<=1 -> START.
//   START
//    - dma_start<=0; wd counter<=0 -> BUSY.
//   BUSY
//    - done_rise -> ch_done[win] pulse, grant<=0 -> IDLE.
//    - Else if wd counter==WD_CYCLES -> ch_err[win] pulse, fault<=1, grant<=0 -> FAULT.
//    - Else increment wd counter.
//   FAULT
//    - Terminal; ignores req; outputs 0 except fault. Exit only via rst_n.
//  Timing:
//   - req sampled in cycle T -> grant/dma_start visible T+1.
//   - done_rise at T+k -> ch_done at T+k+1.
//   - Earliest re-arbitration T+k+2; one-cycle turnaround.
//  Descriptor: dma_src/dest/length hold from start until next grant; later changes on ch_* are ignored.
//  Request dropped after grant: transfer still runs to completion; ch_done still pulses.
//  dma_done already high on entry to BUSY: ignored (edge-based); only a fresh rise counts.
//  Fairness: a channel holding req waits at most NUM_CH-1 transfers.
//  ch_done and ch_err never pulse in the same cycle for the same channel.
//  Width rules: wd counter saturates at compare; ptr wraps NUM_CH-1 -> 0; no arithmetic on addresses.
//  Reset mid-transfer: all state cleared immediately; engine is reset by the same system reset.
// STRUCTURE
//  dma_arb_pkg:
//   - state enum IDLE/START/BUSY/FAULT (2-bit).
//   - Default widths AW/LW.
//   - onehot helper function.
//  Sub-module rr_pick:
//   - Combinational rotating-priority picker (req, ptr -> winner index, valid).
//   - Instantiated once; FSM, descriptor mux/latch and watchdog stay in top.
// TESTING
//  1. Single req[2], src=0x10 dest=0x80 len=3
//     -> grant=0100 and dma_start one cycle after req, dma_*={10,80,03};
//        ch_done[2] one cycle after dma_done rise.
//  2. req=1111 held continuously
//     -> grant order ch0,ch1,ch2,ch3,ch0; exactly one dma_start per grant.
//  3. req[1] with len=0
//     -> ch_err[1] pulse, no dma_start, grant stays 0; req[3] pending is granted next.
//  4. Engine never raises done
//     -> after WD_CYCLES+1 BUSY cycles: ch_err pulse, fault=1, later reqs ignored until rst_n.
//  5. dma_done left high from previous transfer, new grant issued
//     -> no early ch_done; completion only on the next 0->1 edge.
//  6. rst_n low during BUSY
//     -> same cycle grant=0, dma_start=0, fault=0; after release ch0 has priority.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// Holds the FSM state encoding, default widths and the one-hot decode helper.
package dma_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_LW = 8;
  localparam int WD_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Decodes a channel index (0..7) into an 8-bit one-hot vector.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_rr_pick.sv
// Rotating-priority picker: the search starts at the channel just after ptr
// and wraps, so the most recently served channel has the lowest priority.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int PW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     winner,
  output logic              valid
);

  logic [PW-1:0] cand;

  // Walk from the farthest distance down to the nearest so the nearest set request wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = PW'((int'(ptr) + k) % NUM_CH);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares one byte-copy DMA engine among NUM_CH channels with round-robin
// arbitration, descriptor latching, edge-based completion and a BUSY watchdog.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int AW        = DEF_AW,
  parameter int LW        = DEF_LW,
  parameter int WD_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*AW-1:0] ch_src,
  input  logic [NUM_CH*AW-1:0] ch_dest,
  input  logic [NUM_CH*LW-1:0] ch_len,
  output logic [NUM_CH-1:0]    grant,
  output logic [NUM_CH-1:0]    ch_done,
  output logic [NUM_CH-1:0]    ch_err,
  output logic                 fault,
  output logic                 dma_start,
  output logic [AW-1:0]        dma_src,
  output logic [AW-1:0]        dma_dest,
  output logic [LW-1:0]        dma_length,
  input  logic                 dma_done
);

  localparam int              PW     = $clog2(NUM_CH);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_CYCLES);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pick;
  logic            pick_valid;
  logic            dma_done_q;
  logic            done_rise;
  logic [WD_W-1:0] wd_cnt;

  logic [AW-1:0] src_arr  [NUM_CH];
  logic [AW-1:0] dest_arr [NUM_CH];
  logic [LW-1:0] len_arr  [NUM_CH];

  logic [7:0]        pick_oh_full;
  logic [7:0]        win_oh_full;
  logic [NUM_CH-1:0] pick_oh;
  logic [NUM_CH-1:0] win_oh;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign src_arr[gi]  = ch_src[gi*AW +: AW];
    assign dest_arr[gi] = ch_dest[gi*AW +: AW];
    assign len_arr[gi]  = ch_len[gi*LW +: LW];
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign pick_oh_full = onehot(3'(pick));
  assign win_oh_full  = onehot(3'(win));
  assign pick_oh      = pick_oh_full[NUM_CH-1:0];
  assign win_oh       = win_oh_full[NUM_CH-1:0];

  // Completion is edge-based so a done level left over from the last transfer is ignored.
  assign done_rise = dma_done & ~dma_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= PW'(NUM_CH - 1);
      win        <= '0;
      dma_done_q <= 1'b0;
      wd_cnt     <= '0;
      grant      <= '0;
      ch_done    <= '0;
      ch_err     <= '0;
      fault      <= 1'b0;
      dma_start  <= 1'b0;
      dma_src    <= '0;
      dma_dest   <= '0;
      dma_length <= '0;
    end else begin
      dma_done_q <= dma_done;
      ch_done    <= '0;
      ch_err     <= '0;
      dma_start  <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            ptr <= pick;
            if (len_arr[pick] == '0) begin
              ch_err <= pick_oh;
            end else begin
              dma_src    <= src_arr[pick];
              dma_dest   <= dest_arr[pick];
              dma_length <= len_arr[pick];
              grant      <= pick_oh;
              win        <= pick;
              dma_start  <= 1'b1;
              state      <= START;
            end
          end
        end

        START: begin
          wd_cnt <= '0;
          state  <= BUSY;
        end

        BUSY: begin
          if (done_rise) begin
            ch_done <= win_oh;
            grant   <= '0;
            state   <= IDLE;
          end else if (wd_cnt == WD_LIM) begin
            // Engine hung: report against the owner and park until system reset.
            ch_err     <= win_oh;
            fault      <= 1'b1;
            grant      <= '0;
            dma_src    <= '0;
            dma_dest   <= '0;
            dma_length <= '0;
            state      <= FAULT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
